// File: rtl/tilelink_copier_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tilelink_copier_pkg
//
// Shared TileLink-UL definitions used by the block copier and its bench:
//   - TL opcode constants for the A and D channels
//   - tilelink_a : A-channel request bundle driven by an initiator.
//                  a_ready is the initiator's readiness to take D beats.
//   - tilelink_d : D-channel response bundle driven by a responder.
//                  d_ready is the responder's acceptance of the A beat.
//   - clamp_len  : saturating word-count limiter
// -----------------------------------------------------------------------------
package tilelink_copier_pkg;

    // A-channel opcodes
    localparam logic [2:0] Get           = 3'd4;
    localparam logic [2:0] PutFullData   = 3'd0;
    // D-channel opcodes
    localparam logic [2:0] AccessAck     = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [3:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_ready;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [1:0]  d_size;
        logic [3:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        d_ready;
    } tilelink_d;

    // Returns the smaller of a requested word count and a limit.
    function automatic logic [14:0] clamp_len(input logic [14:0] req_len,
                                              input logic [14:0] limit);
        return (req_len > limit) ? limit : req_len;
    endfunction

endpackage

// File: rtl/tilelink_copier.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tilelink_copier
//
// TileLink-UL initiator that copies a block of 32-bit words from one address
// range to another. Each word is moved with a Get followed by a PutFullData;
// exactly one transaction is outstanding at any time.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   command strobe, only looked at while idle
//   src_addr   in   source byte address (bits [1:0] ignored)
//   dst_addr   in   destination byte address (bits [1:0] ignored)
//   len        in   words to copy, clamped to max_len
//   bus_tla    out  A-channel request bundle
//   bus_tld    in   D-channel response bundle (d_ready = A-beat acceptance)
//   busy       out  high whenever the engine is not idle
//   done       out  one-cycle pulse when a copy finishes or aborts
//   error      out  sticky abort flag, cleared by the next accepted start
//   dbg_state  out  current FSM state encoding, for observation only
//
// Handshake: an A beat transfers on any cycle where a_valid and d_ready are
// both high; a_valid then drops until the matching D beat (d_valid) has been
// seen. d_valid outside the two wait states is ignored.
//
// Build option
//   TILELINK_COPIER_WATCHDOG_EN : when defined, each wait state gives up after
//   255 idle cycles with error set. When undefined, the wait states wait
//   forever.
// -----------------------------------------------------------------------------
module tilelink_copier
    import tilelink_copier_pkg::*;
#(
    parameter int unsigned max_len = 16384
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [14:0] len,
    output tilelink_a   bus_tla,
    input  tilelink_d   bus_tld,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    localparam logic [14:0] MaxLenW = 15'(max_len);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] src_q,   src_d;
    logic [31:0] dst_q,   dst_d;
    logic [14:0] count_q, count_d;
    logic [31:0] buf_q,   buf_d;
    logic        error_q, error_d;

`ifdef TILELINK_COPIER_WATCHDOG_EN
    // Idle cycles spent in the current wait state.
    logic [7:0]  wd_q,    wd_d;
`endif

    // Fields of the inputs the copier never looks at: the low address bits
    // are forced to zero and the D opcode/routing fields are not checked.
    logic unused_inputs;
    assign unused_inputs = ^{src_addr[1:0], dst_addr[1:0],
                             bus_tld.d_opcode, bus_tld.d_param,
                             bus_tld.d_size, bus_tld.d_source, bus_tld.d_sink};

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            error_q <= 1'b0;
`ifdef TILELINK_COPIER_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            error_q <= error_d;
`ifdef TILELINK_COPIER_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        buf_d   = buf_q;
        error_d = error_q;
`ifdef TILELINK_COPIER_WATCHDOG_EN
        wd_d    = wd_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Any accepted command clears the previous abort,
                    // including a zero-length one.
                    error_d = 1'b0;
                    if (len != 15'd0) begin
                        src_d   = {src_addr[31:2], 2'b00};
                        dst_d   = {dst_addr[31:2], 2'b00};
                        count_d = clamp_len(len, MaxLenW);
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end

            S_RD_REQ: begin
                if (bus_tld.d_ready) begin
                    state_d = S_RD_WAIT;
`ifdef TILELINK_COPIER_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end

            S_RD_WAIT: begin
                if (bus_tld.d_valid) begin
                    if (bus_tld.d_error) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        buf_d   = bus_tld.d_data;
                        state_d = S_WR_REQ;
                    end
                end
`ifdef TILELINK_COPIER_WATCHDOG_EN
                else if (wd_q == 8'hFF) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end

            S_WR_REQ: begin
                if (bus_tld.d_ready) begin
                    state_d = S_WR_WAIT;
`ifdef TILELINK_COPIER_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end

            S_WR_WAIT: begin
                if (bus_tld.d_valid) begin
                    if (bus_tld.d_error) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        // Addresses wrap naturally modulo 2^32.
                        src_d   = src_q + 32'd4;
                        dst_d   = dst_q + 32'd4;
                        count_d = count_q - 15'd1;
                        state_d = (count_q == 15'd1) ? S_FINISH : S_RD_REQ;
                    end
                end
`ifdef TILELINK_COPIER_WATCHDOG_EN
                else if (wd_q == 8'hFF) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // A-channel drive: decoded from registered state only, so nothing on the
    // D channel can reach the A channel combinationally. While idle the whole
    // bundle is zero; the fixed size/ready fields appear once a copy starts.
    // -------------------------------------------------------------------------
    always_comb begin
        bus_tla = '0;
        if (state_q != S_IDLE) begin
            bus_tla.a_size  = 2'd2;
            bus_tla.a_ready = 1'b1;
        end
        case (state_q)
            S_RD_REQ: begin
                bus_tla.a_valid   = 1'b1;
                bus_tla.a_opcode  = Get;
                bus_tla.a_address = src_q;
                bus_tla.a_mask    = 4'hF;
            end
            S_WR_REQ: begin
                bus_tla.a_valid   = 1'b1;
                bus_tla.a_opcode  = PutFullData;
                bus_tla.a_address = dst_q;
                bus_tla.a_data    = buf_q;
                bus_tla.a_mask    = 4'hF;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tilelink_copier.sv
`timescale 1ns/1ps
module tb_tilelink_copier;
    import tilelink_copier_pkg::*;

    localparam int MAX_LEN = 8;
    typedef logic [95:0] v_t;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [14:0] len      = '0;
    tilelink_a   bus_tla;
    tilelink_d   bus_tld;
    logic        busy, done, error;
    logic [2:0]  dbg_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    tilelink_copier #(.max_len(MAX_LEN)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .bus_tla  (bus_tla),
        .bus_tld  (bus_tld),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------------
    // Responder: word memory indexed by address[9:2], zero-wait by default
    // ------------------------------------------------------------------
    logic [31:0] mem     [0:255];
    logic [31:0] mdl_mem [0:255];
    int  stall_left = 0;
    int  rd_n = 0, wr_n = 0;
    int  err_rd_at = 0, err_wr_at = 0;
    bit  silent = 0;
    bit  smp_acc, smp_stall;
    tilelink_a smp_a;
    logic        d_valid_r = 1'b0;
    logic        d_error_r = 1'b0;
    logic [31:0] d_data_r  = '0;
    logic [2:0]  d_opcode_r = '0;

    always_comb begin
        bus_tld          = '0;
        bus_tld.d_valid  = d_valid_r;
        bus_tld.d_opcode = d_opcode_r;
        bus_tld.d_size   = 2'd2;
        bus_tld.d_data   = d_data_r;
        bus_tld.d_error  = d_error_r;
        bus_tld.d_ready  = (stall_left == 0);
    end

    always @(negedge clock) begin
        smp_acc   = bus_tla.a_valid && bus_tld.d_ready;
        smp_stall = bus_tla.a_valid && (stall_left > 0);
        smp_a     = bus_tla;
    end

    always @(posedge clock) begin
        #1;
        d_valid_r  = 1'b0;
        d_error_r  = 1'b0;
        d_data_r   = '0;
        d_opcode_r = '0;
        if (smp_stall) stall_left = stall_left - 1;
        if (smp_acc) begin
            if (smp_a.a_opcode == Get) begin
                rd_n++;
                d_opcode_r = AccessAckData;
                d_data_r   = mem[smp_a.a_address[9:2]];
                d_error_r  = (rd_n == err_rd_at);
            end else begin
                wr_n++;
                d_opcode_r = AccessAck;
                if (wr_n == err_wr_at) d_error_r = 1'b1;
                else mem[smp_a.a_address[9:2]] = smp_a.a_data;
            end
            d_valid_r = !silent;
        end
        smp_acc   = 0;
        smp_stall = 0;
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [66:0] exp_q[$];          // {opcode, address, data}
    logic [31:0] acc_addr_q[$];
    int  vectors = 0, miscompares = 0;
    int  cmd_start_cyc = -100, cmd_done_cyc = -100;
    bit  cmd_abort = 0, model_err = 0, chk_en = 0;
    int  last_done_cyc = -1;
    int  a_valid_cycles = 0;

    task automatic check(input string name, input v_t act, input v_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model of one command: the request stream it must produce,
    // the memory image afterwards, and the cycle offset of done from start.
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n,
                        input int erd, input int ewr, input int stall, input bit sil,
                        output int done_off, output bit abort);
        logic [31:0] sa, da, v;
        int words;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        words = (n > MAX_LEN) ? MAX_LEN : n;
        done_off = 1 + stall;
        abort = 0;
        for (int i = 1; i <= words; i++) begin
            v = mdl_mem[sa[9:2]];
            exp_q.push_back({Get, sa, 32'h0});
            if (sil) begin
                abort = 1; done_off += 1 + 256; return;
            end
            if (i == erd) begin
                abort = 1; done_off += 2; return;
            end
            exp_q.push_back({PutFullData, da, v});
            done_off += 4;
            if (i == ewr) begin
                abort = 1; return;
            end
            mdl_mem[da[9:2]] = v;
            sa += 32'd4;
            da += 32'd4;
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge clock) begin : compare
        bit exp_busy;
        if (chk_en) begin
            if (cyc == cmd_start_cyc + 1) model_err = 0;
            if (cyc == cmd_done_cyc) model_err = cmd_abort;
            exp_busy = (cyc > cmd_start_cyc) && (cyc <= cmd_done_cyc);
            check("done", v_t'(done), v_t'(cyc == cmd_done_cyc));
            check("busy", v_t'(busy), v_t'(exp_busy));
            check("error", v_t'(error), v_t'(model_err));
            if (done) last_done_cyc = cyc;
            if (!exp_busy) check("idle_bus", v_t'(bus_tla), v_t'(0));
            if (bus_tla.a_valid) begin
                a_valid_cycles++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_req: a_valid=1 addr=%0h, expected no request (cycle %0d)",
                             bus_tla.a_address, cyc);
                end else begin
                    if (exp_q[0][66:64] == Get)
                        check("a_get", v_t'({bus_tla.a_opcode, bus_tla.a_address}), v_t'(exp_q[0][66:32]));
                    else
                        check("a_put", v_t'({bus_tla.a_opcode, bus_tla.a_address, bus_tla.a_data}),
                              v_t'(exp_q[0]));
                    check("a_fixed",
                          v_t'({bus_tla.a_mask, bus_tla.a_size, bus_tla.a_source, bus_tla.a_param, bus_tla.a_ready}),
                          v_t'({4'hF, 2'd2, 4'd0, 3'd0, 1'b1}));
                    if (bus_tld.d_ready) begin
                        acc_addr_q.push_back(bus_tla.a_address);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int erd, input int ewr, input int stall,
                           input bit sil, input bit poke);
        int off;
        bit ab;
        @(posedge clock); #2;
        rd_n = 0; wr_n = 0;
        err_rd_at = erd; err_wr_at = ewr;
        stall_left = stall; silent = sil;
        plan(s, d, n, erd, ewr, stall, sil, off, ab);
        src_addr = s; dst_addr = d; len = 15'(n); start = 1'b1;
        cmd_start_cyc = cyc; cmd_done_cyc = cyc + off; cmd_abort = ab;
        @(posedge clock); #2;
        start = 1'b0;
        for (int k = 1; k <= off; k++) begin
            @(posedge clock); #2;
            if (poke && k == 2) begin
                src_addr = 32'h0; dst_addr = 32'h0; len = 15'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: run did not complete, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int av0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h5500_0000 | i;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + i;
        for (int i = 0; i < 256; i++) mdl_mem[i] = mem[i];

        // reset state
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", v_t'(busy), v_t'(0));
        check("rst_done", v_t'(done), v_t'(0));
        check("rst_error", v_t'(error), v_t'(0));
        check("rst_bus", v_t'(bus_tla), v_t'(0));
        @(posedge clock); #2;
        reset_n = 1'b1;
        chk_en = 1;

        // basic 4-word copy
        run_cmd(32'h40, 32'h100, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) check("copy_data", v_t'(mem[64 + i]), v_t'(32'hA0 + i));
        check("lat_basic", v_t'(last_done_cyc - cmd_start_cyc), v_t'(17));

        // zero length
        av0 = a_valid_cycles;
        run_cmd(32'h200, 32'h300, 0, 0, 0, 0, 0, 0);
        check("len0_traffic", v_t'(a_valid_cycles - av0), v_t'(0));
        check("lat_len0", v_t'(last_done_cyc - cmd_start_cyc), v_t'(1));

        // address wrap, unaligned destination
        acc_addr_q.delete();
        run_cmd(32'hFFFF_FFFC, 32'h83, 2, 0, 0, 0, 0, 0);
        check("wrap_get2", v_t'(acc_addr_q[2]), v_t'(32'h0));
        check("dst_align", v_t'(acc_addr_q[1]), v_t'(32'h80));
        check("wrap_data", v_t'(mem[33]), v_t'(32'h5500_0000));

        // error on second write, then recovery
        run_cmd(32'h40, 32'h180, 3, 0, 2, 0, 0, 0);
        check("err_sticky", v_t'(error), v_t'(1));
        check("err_word0", v_t'(mem[96]), v_t'(32'hA0));
        check("err_word1", v_t'(mem[97]), v_t'(32'h5500_0061));
        run_cmd(32'h40, 32'h1C0, 1, 0, 0, 0, 0, 0);
        check("err_cleared", v_t'(error), v_t'(0));

        // error on first read
        run_cmd(32'h40, 32'h200, 2, 1, 0, 0, 0, 0);

        // d_ready low for 5 cycles on the first Get
        run_cmd(32'h44, 32'h240, 2, 0, 0, 5, 0, 0);
        check("lat_stall", v_t'(last_done_cyc - cmd_start_cyc), v_t'(14));

        // length clamp
        run_cmd(32'h0, 32'h300, 20, 0, 0, 0, 0, 0);
        check("lat_clamp", v_t'(last_done_cyc - cmd_start_cyc), v_t'(33));

        // start while busy is ignored
        run_cmd(32'h48, 32'h340, 2, 0, 0, 0, 0, 1);

        // overlapping ascending copy
        run_cmd(32'h100, 32'h104, 3, 0, 0, 0, 0, 0);
        check("overlap", v_t'(mem[67]), v_t'(32'hA0));

`ifdef TILELINK_COPIER_WATCHDOG_EN
        run_cmd(32'h40, 32'h380, 1, 0, 0, 0, 1, 0);
        check("lat_watchdog", v_t'(last_done_cyc - cmd_start_cyc), v_t'(258));
        check("wd_error", v_t'(error), v_t'(1));
`endif

        // reset in the middle of a copy
        check("queue_drained", v_t'(exp_q.size()), v_t'(0));
        chk_en = 0;
        @(posedge clock); #2;
        rd_n = 0; wr_n = 0; err_rd_at = 0; err_wr_at = 0; stall_left = 0; silent = 0;
        src_addr = 32'h40; dst_addr = 32'h3C0; len = 15'd4; start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", v_t'(busy), v_t'(0));
        check("midrst_done", v_t'(done), v_t'(0));
        check("midrst_error", v_t'(error), v_t'(0));
        check("midrst_bus", v_t'(bus_tla), v_t'(0));
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 256; i++) mdl_mem[i] = mem[i];
        exp_q.delete();
        cmd_start_cyc = -100; cmd_done_cyc = -100; cmd_abort = 0; model_err = 0;
        chk_en = 1;
        repeat (3) @(posedge clock);

        // recovery after reset
        run_cmd(32'h4C, 32'h3E0, 1, 0, 0, 0, 0, 0);
        check("queue_empty_end", v_t'(exp_q.size()), v_t'(0));
        for (int i = 0; i < 256; i++) check("mem_image", v_t'(mem[i]), v_t'(mdl_mem[i]));

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tilelink_copier.md
# tilelink_copier

TileLink-UL initiator that copies a block of 32-bit words from one address range to another by issuing alternating Get and PutFullData requests on the A channel. It sits on the initiator side of the pinwheel TileLink bus, in front of `block_ram` and other UL responders. It offloads memory-to-memory copies from the core. It holds one outstanding transaction at a time.

## Interface
Parameters:
- `max_len`, 16384: largest accepted word count; longer requests are clamped to this value.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: command strobe; sampled only in IDLE.
- `src_addr`  in  32: source byte address; bits [1:0] are ignored (treated as 0).
- `dst_addr`  in  32: destination byte address; bits [1:0] are ignored (treated as 0).
- `len`  in  15: number of words to copy.
- `bus_tla`  out  tilelink_a: A-channel request.
- `bus_tld`  in  tilelink_d: D-channel response. `d_ready` is the responder's A-channel acceptance.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when a copy completes or aborts.
- `error`  out  1: sticky; set on abort; cleared by the next accepted `start`.

## Operation
States and transitions:
- IDLE:
  - If `start` and `len != 0`: latch `src`, `dst`, and `count = min(len, max_len)`; go to RD_REQ.
  - If `start` and `len == 0`: go to FINISH.
- RD_REQ: drive a Get with `a_address = src` and `a_mask = 4'hF`. When `bus_tld.d_ready` is high, go to RD_WAIT.
- RD_WAIT:
  - On `d_valid` with `d_error == 0`: latch `d_data` into `buf`; go to WR_REQ.
  - On `d_valid` with `d_error == 1`: set `error`; go to FINISH.
- WR_REQ: drive a PutFullData with `a_address = dst`, `a_data = buf`, `a_mask = 4'hF`. When `d_ready` is high, go to WR_WAIT.
- WR_WAIT: on `d_valid`:
  - Error response: set `error`; go to FINISH.
  - Otherwise: `src += 4`, `dst += 4`, `count -= 1`. If the new `count` is 0, go to FINISH; otherwise go to RD_REQ.
- FINISH: pulse `done`; go to IDLE.

Bus rules:
- `a_valid` is high only in RD_REQ and WR_REQ.
- All `bus_tla` fields are combinational from registered state only. There is no combinational path from `bus_tld` to `bus_tla`.
- Fixed A-channel field values: `a_size = 2`, `a_source = 0`, `a_param = 0`, `a_ready = 1`.
- `d_valid` outside RD_WAIT and WR_WAIT is ignored. The D-channel opcode is not checked.

Boundary and corner cases:
- Address increments wrap modulo 2^32.
- `start` while `busy` is ignored; the command inputs are not re-sampled.
- Overlapping ranges are copied in ascending address order with no hazard detection.

Reset values: state IDLE, `busy = 0`, `done = 0`, `error = 0`, `a_valid = 0`, all other `bus_tla` fields 0, and `count`, `src`, `dst`, `buf` all 0. Asserting reset mid-copy abandons the transfer; a late response arriving after reset is ignored because the block is in IDLE.

## Timing
- `start` is sampled at edge N. From cycle N+1 the block is in RD_REQ with `busy = 1`.
- Against a zero-wait responder (accepts the same cycle, responds the next), each word costs 4 cycles: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- A copy of L words (L ≥ 1) asserts `done` in cycle N+1+4L; `busy` falls in the following cycle.
- `len = 0`: `done` is asserted in cycle N+1 and no bus traffic occurs.
- Requests stall indefinitely while `d_ready` is low.

## Configuration
- Macro: `TILELINK_COPIER_WATCHDOG_EN`.
- Defined: an 8-bit counter clears on entry to RD_WAIT or WR_WAIT and increments each cycle spent waiting. When it reaches 255 without a `d_valid`, the block sets `error` and goes to FINISH.
- Undefined: the counter is absent and the wait states wait forever.

## Structure
- `tilelink_a`, `tilelink_d`, and the TL opcode constants (`Get`, `PutFullData`, `AccessAck`, `AccessAckData`) come from the existing shared tilelink package; no new package fields.
- The state enum is local to the module.
- Single module; no sub-module is warranted. The watchdog is a few lines inside the same module.

## Test plan
- `block_ram` as responder, preloaded with `mem[0x10..0x13] = 0xA0..0xA3`; copy `src = 0x40`, `dst = 0x100`, `len = 4` -> `mem[0x40..0x43] = 0xA0..0xA3`, `done` exactly 17 cycles after `start`, `error = 0`.
- `len = 0` -> `done` one cycle after `start`, `a_valid` never asserted.
- `src = 0xFFFFFFFC`, `len = 2`, behind a mock responder -> second Get address is `0x00000000`.
- Mock responder returns `d_error = 1` on the second write -> `error = 1`, exactly one word written, `done` pulses, then a new `start` clears `error`.
- `d_ready` held low for 5 cycles in RD_REQ -> `a_valid` and `a_address` held stable throughout; per-word time grows by 5 cycles.
- With `TILELINK_COPIER_WATCHDOG_EN` and a responder that never answers -> `error = 1` and `done` 256 cycles after entering RD_WAIT. Reset asserted mid-copy -> all outputs return to reset values immediately.
